// File: rtl/mmss_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : mmss_timer_core
//  Purpose  : MM:SS stopwatch / countdown timer with pause, clear, per-field
//             adjust, field blink and a 4-digit multiplexed 7-segment driver.
//  Revision : 1.0  initial release
// ============================================================================
module mmss_timer_core #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 25_000_000,
  parameter int MIN_MAX   = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       pause,
  input  logic       count_down,
  input  logic       adj_en,
  input  logic       adj_sel,
  input  logic       adj_pulse,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       tick,
  output logic       zero,
  output logic [5:0] sec,
  output logic [6:0] min
);

  // Counter widths; a divide-by-one still needs a 1-bit counter.
  localparam int c_PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int c_SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [c_PW-1:0] c_PRE_LAST   = c_PW'(TICK_DIV - 1);
  localparam logic [c_SW-1:0] c_SCAN_LAST  = c_SW'(SCAN_DIV - 1);
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);
  localparam logic [6:0]      c_MIN_MAX    = 7'(MIN_MAX);

  // Time-keeping state
  logic [c_PW-1:0] presc_q, presc_d;
  logic [5:0]      sec_q, sec_d;
  logic [6:0]      min_q, min_d;
  logic            tick_q, tick_d;
  logic            zero_q, zero_d;

  // Display / blink state
  logic [c_SW-1:0] scan_q;
  logic [1:0]      idx_q;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [c_BW-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic            adj_en_q;

  logic            w_run;
  logic [3:0]      w_digit;

  assign w_run = !pause && !adj_en;

  // Next-state for time, prescaler, tick and zero; clear beats adjust beats tick.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    tick_d  = 1'b0;
    zero_d  = zero_q;
    if (clear) begin
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
      zero_d  = 1'b0;
    end else if (adj_en && adj_pulse) begin
      zero_d = 1'b0;
      if (adj_sel) begin
        min_d = (min_q == c_MIN_MAX) ? 7'd0 : min_q + 7'd1;
      end else begin
        sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      end
    end else if (w_run) begin
      if (presc_q == c_PRE_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (count_down) begin
          if (sec_q == 6'd0 && min_q == 7'd0) begin
            zero_d = 1'b1;
          end else begin
            if (sec_q == 6'd0) begin
              sec_d = 6'd59;
              min_d = min_q - 7'd1;
            end else begin
              sec_d = sec_q - 6'd1;
            end
            if (sec_q == 6'd1 && min_q == 7'd0) begin
              zero_d = 1'b1;
            end
          end
        end else begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            min_d = (min_q == c_MIN_MAX) ? 7'd0 : min_q + 7'd1;
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end else begin
        presc_d = presc_q + c_PW'(1);
      end
    end
    // The expired flag only has meaning in countdown mode.
    if (!count_down) begin
      zero_d = 1'b0;
    end
  end

  // Time-keeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      tick_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      tick_q  <= tick_d;
      zero_q  <= zero_d;
    end
  end

  // Blink phase restarts on entry to adjust mode and holds outside it.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (adj_en && !adj_en_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (adj_en) begin
      if (blink_cnt_q == c_BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + c_BW'(1);
      end
    end
  end

  // Blink registers and adjust-mode edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      adj_en_q    <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      adj_en_q    <= adj_en;
    end
  end

  // Digit scan position: advance one digit every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
    end else if (scan_q == c_SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      scan_q <= scan_q + c_SW'(1);
    end
  end

  // Decimal digit currently being scanned, derived from the binary fields.
  always_comb begin
    w_digit = 4'd0;
    case (idx_q)
      2'd0: w_digit = 4'(sec_q % 6'd10);
      2'd1: w_digit = 4'(sec_q / 6'd10);
      2'd2: w_digit = 4'(min_q % 7'd10);
      2'd3: w_digit = 4'(min_q / 7'd10);
      default: w_digit = 4'd0;
    endcase
  end

  // Segment pattern and anode select, with the adjusted field blanked while blinking.
  always_comb begin
    seg_d = 7'h7F;
    case (w_digit)
      4'd0: seg_d = 7'h40;
      4'd1: seg_d = 7'h79;
      4'd2: seg_d = 7'h24;
      4'd3: seg_d = 7'h30;
      4'd4: seg_d = 7'h19;
      4'd5: seg_d = 7'h12;
      4'd6: seg_d = 7'h02;
      4'd7: seg_d = 7'h78;
      4'd8: seg_d = 7'h00;
      4'd9: seg_d = 7'h10;
      default: seg_d = 7'h7F;
    endcase
    an_d = ~(4'b0001 << idx_q);
    // idx[1] distinguishes the seconds pair (0,1) from the minutes pair (2,3).
    if (adj_en && blink_q && (adj_sel == idx_q[1])) begin
      an_d = 4'b1111;
    end
  end

  // Display output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 4'b1110;
      seg_q <= 7'h40;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign tick = tick_q;
  assign zero = zero_q;
  assign sec  = sec_q;
  assign min  = min_q;

endmodule
`default_nettype wire
